// File: rtl/mem_arb16_if.sv
// Requester/RAM bundle for the two-port cpu16 memory arbiter.
// slave is the arbiter side, master is the requesters plus RAM.
interface mem_arb16_if #(
    parameter int ADDR_W = 16
);
    logic              ins_rd_req;
    logic [ADDR_W-1:0] ins_rd_addr;
    logic              ins_rd_gnt;
    logic [15:0]       ins_rd_data;
    logic              ins_rd_rdy;

    logic              dat_rd_req;
    logic              dat_wr_req;
    logic [ADDR_W-1:0] dat_rw_addr;
    logic [15:0]       dat_wr_data;
    logic              dat_gnt;
    logic [15:0]       dat_rd_data;
    logic              dat_rd_rdy;
    logic              dat_wr_rdy;
    logic              proto_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [15:0]       mem_rdata;

    modport slave (
        input  ins_rd_req,
        input  ins_rd_addr,
        output ins_rd_gnt,
        output ins_rd_data,
        output ins_rd_rdy,
        input  dat_rd_req,
        input  dat_wr_req,
        input  dat_rw_addr,
        input  dat_wr_data,
        output dat_gnt,
        output dat_rd_data,
        output dat_rd_rdy,
        output dat_wr_rdy,
        output proto_err,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport master (
        output ins_rd_req,
        output ins_rd_addr,
        input  ins_rd_gnt,
        input  ins_rd_data,
        input  ins_rd_rdy,
        output dat_rd_req,
        output dat_wr_req,
        output dat_rw_addr,
        output dat_wr_data,
        input  dat_gnt,
        input  dat_rd_data,
        input  dat_rd_rdy,
        input  dat_wr_rdy,
        input  proto_err,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arb16.sv
// Fetch/data arbiter onto one 16-bit single-port synchronous RAM.
// Data wins by default; a starvation counter forces pending fetches through.
module mem_arb16 #(
    parameter int INS_STARVE_MAX = 4,
    parameter int ADDR_W         = 16
) (
    input  logic      clk,
    input  logic      reset,
    mem_arb16_if.slave bus
);
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_INS  = 2'd1,
        TAG_RD   = 2'd2,
        TAG_WR   = 2'd3
    } tag_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(INS_STARVE_MAX);

    tag_t        r_tag;
    logic [3:0]  r_starve_cnt;
    logic        r_proto_err;
    logic [15:0] r_ins_hold;
    logic [15:0] r_dat_hold;

    logic              w_dat_req;
    logic              w_force_ins;
    logic              w_ins_gnt;
    logic              w_dat_gnt;
    logic              w_dat_wr;
    logic              w_ins_rdy;
    logic              w_dat_rd_rdy;
    logic              w_dat_wr_rdy;
    tag_t              w_tag_nxt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [15:0]       w_mem_wdata;

    assign w_dat_req   = bus.dat_rd_req | bus.dat_wr_req;
    assign w_force_ins = bus.ins_rd_req && (r_starve_cnt == LP_STARVE_MAX);

    // Grants are suppressed during reset so nothing reaches the RAM.
    assign w_ins_gnt = !reset && bus.ins_rd_req && (w_force_ins || !w_dat_req);
    assign w_dat_gnt = !reset && w_dat_req && !w_force_ins;

    // A simultaneous read+write request is executed as a write only.
    assign w_dat_wr = bus.dat_wr_req;

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_tag_nxt   = TAG_NONE;
        unique case (1'b1)
            w_ins_gnt: begin
                w_mem_addr = bus.ins_rd_addr;
                w_tag_nxt  = TAG_INS;
            end
            w_dat_gnt: begin
                w_mem_addr = bus.dat_rw_addr;
                if (w_dat_wr) begin
                    w_mem_wdata = bus.dat_wr_data;
                    w_tag_nxt   = TAG_WR;
                end else begin
                    w_tag_nxt   = TAG_RD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag        <= TAG_NONE;
            r_starve_cnt <= '0;
            r_proto_err  <= 1'b0;
            r_ins_hold   <= '0;
            r_dat_hold   <= '0;
        end else begin
            r_tag <= w_tag_nxt;
            if (w_ins_gnt || !bus.ins_rd_req) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != LP_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (bus.dat_rd_req && bus.dat_wr_req) begin
                r_proto_err <= 1'b1;
            end
            if (r_tag == TAG_INS) begin
                r_ins_hold <= bus.mem_rdata;
            end
            if (r_tag == TAG_RD) begin
                r_dat_hold <= bus.mem_rdata;
            end
        end
    end

    // An in-flight return is squashed by reset before its edge lands.
    assign w_ins_rdy    = !reset && (r_tag == TAG_INS);
    assign w_dat_rd_rdy = !reset && (r_tag == TAG_RD);
    assign w_dat_wr_rdy = !reset && (r_tag == TAG_WR);

    assign bus.ins_rd_gnt  = w_ins_gnt;
    assign bus.dat_gnt     = w_dat_gnt;
    assign bus.ins_rd_rdy  = w_ins_rdy;
    assign bus.dat_rd_rdy  = w_dat_rd_rdy;
    assign bus.dat_wr_rdy  = w_dat_wr_rdy;
    assign bus.ins_rd_data = w_ins_rdy ? bus.mem_rdata : r_ins_hold;
    assign bus.dat_rd_data = w_dat_rd_rdy ? bus.mem_rdata : r_dat_hold;
    assign bus.proto_err   = r_proto_err;

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_re    = w_ins_gnt | (w_dat_gnt & !w_dat_wr);
    assign bus.mem_we    = w_dat_gnt & w_dat_wr;

    a_gnt_excl: assert property (@(posedge clk) !(w_ins_gnt && w_dat_gnt));
endmodule

// File: tb/tb_mem_arb16.sv
// Directed-vector bench for mem_arb16 with a behavioural RAM model.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_mem_arb16;
    logic clk;
    logic reset;
    int   vecs;
    int   errs;

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [15:0] pre_data;
    logic [15:0] ram [0:65535];

    mem_arb16_if #(.ADDR_W(16)) bus ();

    mem_arb16 #(
        .INS_STARVE_MAX(4),
        .ADDR_W        (16)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic idle();
        bus.ins_rd_req  = 1'b0;
        bus.ins_rd_addr = '0;
        bus.dat_rd_req  = 1'b0;
        bus.dat_wr_req  = 1'b0;
        bus.dat_rw_addr = '0;
        bus.dat_wr_data = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        next();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        bus.dat_wr_req  = 1'b1;
        bus.dat_rw_addr = 16'h0005;
        bus.dat_wr_data = 16'hAAAA;
        bus.ins_rd_req  = 1'b1;
        bus.ins_rd_addr = 16'h0010;
        @(negedge clk);
        vecs++;
        if (bus.ins_rd_gnt !== 1'b0) begin
            errs++;
            $display("FAIL rst_ins_gnt got %0b want 0", bus.ins_rd_gnt);
        end
        vecs++;
        if (bus.dat_gnt !== 1'b0) begin
            errs++;
            $display("FAIL rst_dat_gnt got %0b want 0", bus.dat_gnt);
        end
        vecs++;
        if (bus.mem_we !== 1'b0) begin
            errs++;
            $display("FAIL rst_mem_we got %0b want 0", bus.mem_we);
        end
        vecs++;
        if (bus.mem_re !== 1'b0) begin
            errs++;
            $display("FAIL rst_mem_re got %0b want 0", bus.mem_re);
        end
        next();
        idle();
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if ({bus.ins_rd_rdy, bus.dat_rd_rdy, bus.dat_wr_rdy} !== 3'b000) begin
            errs++;
            $display("FAIL rst_rdy got %b want 000",
                     {bus.ins_rd_rdy, bus.dat_rd_rdy, bus.dat_wr_rdy});
        end
        vecs++;
        if (bus.proto_err !== 1'b0) begin
            errs++;
            $display("FAIL rst_proto got %0b want 0", bus.proto_err);
        end
        vecs++;
        if (u_dut.r_starve_cnt !== 4'd0) begin
            errs++;
            $display("FAIL rst_starve got %0d want 0", u_dut.r_starve_cnt);
        end
        next();
        bus.dat_rd_req  = 1'b1;
        bus.dat_rw_addr = 16'h0005;
        next();
        idle();
        @(negedge clk);
        vecs++;
        if (bus.dat_rd_rdy !== 1'b1 || bus.dat_rd_data !== 16'h5555) begin
            errs++;
            $display("FAIL rst_no_write rdy %0b data %h want 1 5555",
                     bus.dat_rd_rdy, bus.dat_rd_data);
        end
        next();
    endtask

    task automatic test_lone_fetch();
        bus.ins_rd_req  = 1'b1;
        bus.ins_rd_addr = 16'h0010;
        @(negedge clk);
        vecs++;
        if (bus.ins_rd_gnt !== 1'b1 || bus.dat_gnt !== 1'b0) begin
            errs++;
            $display("FAIL fetch_gnt got ins %0b dat %0b want 1 0",
                     bus.ins_rd_gnt, bus.dat_gnt);
        end
        vecs++;
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0010) begin
            errs++;
            $display("FAIL fetch_issue re %0b addr %h want 1 0010",
                     bus.mem_re, bus.mem_addr);
        end
        next();
        idle();
        @(negedge clk);
        vecs++;
        if (bus.ins_rd_rdy !== 1'b1 || bus.ins_rd_data !== 16'h1234) begin
            errs++;
            $display("FAIL fetch_rdy rdy %0b data %h want 1 1234",
                     bus.ins_rd_rdy, bus.ins_rd_data);
        end
        next();
        @(negedge clk);
        vecs++;
        if (bus.ins_rd_rdy !== 1'b0 || bus.ins_rd_data !== 16'h1234) begin
            errs++;
            $display("FAIL fetch_hold rdy %0b data %h want 0 1234",
                     bus.ins_rd_rdy, bus.ins_rd_data);
        end
        next();
    endtask

    task automatic test_contention();
        logic       exp_ins;
        logic       exp_drdy;
        logic [3:0] exp_cnt;
        bus.ins_rd_req  = 1'b1;
        bus.ins_rd_addr = 16'h0010;
        bus.dat_rd_req  = 1'b1;
        bus.dat_rw_addr = 16'h0000;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            exp_ins  = (c == 5);
            exp_drdy = (c >= 2) && (c != 6);
            exp_cnt  = (c <= 5) ? 4'(c - 1) : 4'(c - 6);
            vecs++;
            if (bus.ins_rd_gnt !== exp_ins || bus.dat_gnt !== !exp_ins) begin
                errs++;
                $display("FAIL cont_gnt c%0d ins %0b dat %0b want ins %0b",
                         c, bus.ins_rd_gnt, bus.dat_gnt, exp_ins);
            end
            vecs++;
            if (u_dut.r_starve_cnt !== exp_cnt) begin
                errs++;
                $display("FAIL cont_starve c%0d got %0d want %0d",
                         c, u_dut.r_starve_cnt, exp_cnt);
            end
            vecs++;
            if (bus.dat_rd_rdy !== exp_drdy) begin
                errs++;
                $display("FAIL cont_drdy c%0d got %0b want %0b",
                         c, bus.dat_rd_rdy, exp_drdy);
            end
            if (c == 6) begin
                vecs++;
                if (bus.ins_rd_rdy !== 1'b1 || bus.ins_rd_data !== 16'h1234) begin
                    errs++;
                    $display("FAIL cont_irdy rdy %0b data %h want 1 1234",
                             bus.ins_rd_rdy, bus.ins_rd_data);
                end
            end
            if (exp_drdy) begin
                vecs++;
                if (bus.dat_rd_data !== 16'hA000) begin
                    errs++;
                    $display("FAIL cont_ddata c%0d got %h want A000",
                             c, bus.dat_rd_data);
                end
            end
            next();
        end
        idle();
        next();
    endtask

    task automatic test_store_load();
        bus.dat_wr_req  = 1'b1;
        bus.dat_rw_addr = 16'h0100;
        bus.dat_wr_data = 16'hBEEF;
        @(negedge clk);
        vecs++;
        if (bus.dat_gnt !== 1'b1 || bus.mem_we !== 1'b1 ||
            bus.mem_re !== 1'b0 || bus.mem_wdata !== 16'hBEEF) begin
            errs++;
            $display("FAIL st_issue gnt %0b we %0b re %0b wd %h want 1 1 0 BEEF",
                     bus.dat_gnt, bus.mem_we, bus.mem_re, bus.mem_wdata);
        end
        next();
        bus.dat_wr_req = 1'b0;
        bus.dat_rd_req = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.dat_wr_rdy !== 1'b1 || bus.mem_re !== 1'b1) begin
            errs++;
            $display("FAIL st_wrdy wrdy %0b re %0b want 1 1",
                     bus.dat_wr_rdy, bus.mem_re);
        end
        next();
        idle();
        @(negedge clk);
        vecs++;
        if (bus.dat_rd_rdy !== 1'b1 || bus.dat_rd_data !== 16'hBEEF ||
            bus.dat_wr_rdy !== 1'b0) begin
            errs++;
            $display("FAIL ld_rdy rdy %0b data %h wrdy %0b want 1 BEEF 0",
                     bus.dat_rd_rdy, bus.dat_rd_data, bus.dat_wr_rdy);
        end
        next();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        for (int k = 0; k < 3; k++) begin
            bus.ins_rd_req  = 1'b1;
            bus.ins_rd_addr = 16'(k);
            @(negedge clk);
            vecs++;
            if (bus.ins_rd_gnt !== 1'b1) begin
                errs++;
                $display("FAIL b2b_gnt k%0d got %0b want 1", k, bus.ins_rd_gnt);
            end
            if (k > 0) begin
                exp = 16'hA000 + 16'(k - 1);
                vecs++;
                if (bus.ins_rd_rdy !== 1'b1 || bus.ins_rd_data !== exp) begin
                    errs++;
                    $display("FAIL b2b_rdy k%0d rdy %0b data %h want 1 %h",
                             k, bus.ins_rd_rdy, bus.ins_rd_data, exp);
                end
            end
            next();
        end
        idle();
        @(negedge clk);
        vecs++;
        if (bus.ins_rd_rdy !== 1'b1 || bus.ins_rd_data !== 16'hA002) begin
            errs++;
            $display("FAIL b2b_last rdy %0b data %h want 1 A002",
                     bus.ins_rd_rdy, bus.ins_rd_data);
        end
        next();
        @(negedge clk);
        vecs++;
        if (bus.ins_rd_rdy !== 1'b0) begin
            errs++;
            $display("FAIL b2b_end rdy %0b want 0", bus.ins_rd_rdy);
        end
        next();
    endtask

    task automatic test_proto_err();
        bus.dat_rd_req  = 1'b1;
        bus.dat_wr_req  = 1'b1;
        bus.dat_rw_addr = 16'h0200;
        bus.dat_wr_data = 16'h0F0F;
        @(negedge clk);
        vecs++;
        if (bus.dat_gnt !== 1'b1 || bus.mem_we !== 1'b1 ||
            bus.mem_re !== 1'b0 || bus.proto_err !== 1'b0) begin
            errs++;
            $display("FAIL pe_issue gnt %0b we %0b re %0b pe %0b want 1 1 0 0",
                     bus.dat_gnt, bus.mem_we, bus.mem_re, bus.proto_err);
        end
        next();
        idle();
        @(negedge clk);
        vecs++;
        if (bus.dat_wr_rdy !== 1'b1 || bus.dat_rd_rdy !== 1'b0 ||
            bus.proto_err !== 1'b1) begin
            errs++;
            $display("FAIL pe_ret wrdy %0b rrdy %0b pe %0b want 1 0 1",
                     bus.dat_wr_rdy, bus.dat_rd_rdy, bus.proto_err);
        end
        next();
        next();
        next();
        bus.dat_rd_req  = 1'b1;
        bus.dat_rw_addr = 16'h0200;
        next();
        idle();
        @(negedge clk);
        vecs++;
        if (bus.dat_rd_rdy !== 1'b1 || bus.dat_rd_data !== 16'h0F0F ||
            bus.proto_err !== 1'b1) begin
            errs++;
            $display("FAIL pe_hold rdy %0b data %h pe %0b want 1 0F0F 1",
                     bus.dat_rd_rdy, bus.dat_rd_data, bus.proto_err);
        end
        next();
    endtask

    task automatic test_reset_midflight();
        bus.dat_rd_req  = 1'b1;
        bus.dat_rw_addr = 16'h0001;
        @(negedge clk);
        vecs++;
        if (bus.dat_gnt !== 1'b1) begin
            errs++;
            $display("FAIL mr_gnt got %0b want 1", bus.dat_gnt);
        end
        next();
        idle();
        reset = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.dat_rd_rdy !== 1'b0) begin
            errs++;
            $display("FAIL mr_rdy_in_rst got %0b want 0", bus.dat_rd_rdy);
        end
        next();
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if ({bus.ins_rd_rdy, bus.dat_rd_rdy, bus.dat_wr_rdy} !== 3'b000 ||
            bus.proto_err !== 1'b0 || u_dut.r_starve_cnt !== 4'd0) begin
            errs++;
            $display("FAIL mr_after rdy %b pe %0b cnt %0d want 000 0 0",
                     {bus.ins_rd_rdy, bus.dat_rd_rdy, bus.dat_wr_rdy},
                     bus.proto_err, u_dut.r_starve_cnt);
        end
        next();
        bus.dat_rd_req  = 1'b1;
        bus.dat_rw_addr = 16'h0002;
        next();
        idle();
        @(negedge clk);
        vecs++;
        if (bus.dat_rd_rdy !== 1'b1 || bus.dat_rd_data !== 16'hA002) begin
            errs++;
            $display("FAIL mr_resume rdy %0b data %h want 1 A002",
                     bus.dat_rd_rdy, bus.dat_rd_data);
        end
        next();
    endtask

    initial begin
        vecs   = 0;
        errs   = 0;
        reset  = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        idle();
        next();
        preload(16'h0010, 16'h1234);
        preload(16'h0000, 16'hA000);
        preload(16'h0001, 16'hA001);
        preload(16'h0002, 16'hA002);
        preload(16'h0005, 16'h5555);
        test_reset();
        test_lone_fetch();
        test_contention();
        test_store_load();
        test_back_to_back();
        test_proto_err();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/mem_arb16.md
Name: mem_arb16

Overview:
- Two-port-to-one arbiter that lets the cpu16 instruction-fetch port and data load/store port share a single 16-bit-wide single-port synchronous RAM.
- One memory access is issued per cycle.
- Data accesses have priority over fetches. A starvation counter guarantees forward progress for fetches.
- Read data returns one cycle after issue. Each requester receives a registered ready pulse together with its data.

Parameters:
INS_STARVE_MAX, 4, consecutive cycles a pending fetch may be denied before it is forced ahead of data (range 1..15)
ADDR_W, 16, memory word-address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ins_rd_req  in  1  fetch request
ins_rd_addr  in  ADDR_W  fetch word address
ins_rd_gnt  out  1  combinational; fetch accepted this cycle
ins_rd_data  out  16  fetch data, valid when ins_rd_rdy
ins_rd_rdy  out  1  registered; fetch data valid
dat_rd_req  in  1  load request
dat_wr_req  in  1  store request
dat_rw_addr  in  ADDR_W  load/store word address
dat_wr_data  in  16  store data
dat_gnt  out  1  combinational; load or store accepted this cycle
dat_rd_data  out  16  load data, valid when dat_rd_rdy
dat_rd_rdy  out  1  registered; load data valid
dat_wr_rdy  out  1  registered; store committed
proto_err  out  1  sticky; set when dat_rd_req and dat_wr_req are high together
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  16  RAM write data
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe
mem_rdata  in  16  RAM read data; valid the cycle after mem_re

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: all rdy outputs 0, proto_err 0, starve_cnt 0, in-flight tag idle. Gnt and mem_* are combinational and are 0 while reset is high.
- Grant, evaluated each cycle:
  - If starve_cnt == INS_STARVE_MAX and ins_rd_req is high, the fetch wins.
  - Otherwise, any data request wins.
  - Otherwise, ins_rd_req wins.
  - Exactly one of ins_rd_gnt and dat_gnt is high, or neither.
- Requester rule: hold req, addr and wdata stable until the cycle its gnt is high. The transaction is accepted at that edge. A new request may be presented the following cycle, giving back-to-back throughput of 1/cycle.
- Issue path:
  - mem_addr and mem_wdata mux from the winner.
  - mem_re = fetch granted OR data read granted.
  - mem_we = data write granted.
- Read-write conflict: dat_rd_req and dat_wr_req both high is treated as a write; the read is dropped and proto_err is set. proto_err is cleared only by reset.
- Return path:
  - A 2-bit tag register records the grant: {none, ins, dat_rd, dat_wr}.
  - Next cycle: tag ins → ins_rd_rdy=1 with ins_rd_data=mem_rdata. Tag dat_rd → dat_rd_rdy=1 with dat_rd_data=mem_rdata. Tag dat_wr → dat_wr_rdy=1.
  - Rdy outputs are single-cycle pulses.
  - Data outputs hold their last value when rdy is low.
- Latency: rdy is exactly 1 cycle after the gnt cycle, whether or not the port is contended.
- Starvation counter (4-bit):
  - Increments when ins_rd_req is high and ins_rd_gnt is low, saturating at INS_STARVE_MAX.
  - Clears on ins_rd_gnt or when ins_rd_req is low.
- Reset mid-operation: the in-flight tag is discarded and no rdy is pulsed after reset. A write granted in the same cycle that reset is high is NOT issued (mem_we=0).
- Addresses are passed unmodified with no wrap logic; the RAM decodes the full ADDR_W.

Test Plan:
- Lone fetch: ins_rd_req=1, addr=0x0010 with RAM[0x10]=0x1234 → ins_rd_gnt=1 same cycle; next cycle ins_rd_rdy=1 and ins_rd_data=0x1234.
- Contention: ins and dat_rd requests both held → dat_gnt wins. Continuous data reads with INS_STARVE_MAX=4 → fetch is granted on the 5th cycle, then data resumes; counter observed at 0 after the fetch grant.
- Store then load same address: dat_wr addr 0x0100 data 0xBEEF, next cycle dat_rd 0x0100 → dat_wr_rdy on cycle 1; dat_rd_rdy on cycle 2 with 0xBEEF.
- Back-to-back fetches at addresses 0,1,2 with RAM pre-loaded → three consecutive ins_rd_rdy pulses with the matching data and no bubbles.
- Protocol error: dat_rd_req=dat_wr_req=1 → write performed, no dat_rd_rdy, proto_err=1 and held until reset.
- Reset mid-flight: grant a data read, then assert reset the next cycle → dat_rd_rdy stays 0, all outputs return to reset values, and a request after reset releases completes normally.
